// File: rtl/adc_train_pkg.sv
// Shared definitions for the ADC lane delay trainer.
//   train_state_t : training FSM state encoding
//   PAT_*         : pattern-type codes understood by the lane pattern checker
package adc_train_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_DWELL,
        ST_DRAIN,
        ST_EVAL,
        ST_CENTER,
        ST_FIN
    } train_state_t;

    localparam logic [3:0] PAT_ZERO    = 4'h0;
    localparam logic [3:0] PAT_ONES    = 4'h1;
    localparam logic [3:0] PAT_CHECKER = 4'h4;
    localparam logic [3:0] PAT_PN23    = 4'h5;
    localparam logic [3:0] PAT_PN9     = 4'h6;
    localparam logic [3:0] PAT_TOGGLE  = 4'h7;
    localparam logic [3:0] PAT_AAA     = 4'h9;
    localparam logic [3:0] PAT_SYNC    = 4'hA;

endpackage

// File: rtl/eye_run_tracker.sv
// Tracks runs of error-free taps during a delay sweep and keeps the longest.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   clear        : wipe all run state at the start of a sweep
//   eval         : one-cycle strobe, the current tap's result is valid
//   pass         : current tap was error-free
//   last         : current tap is the final tap of the sweep
//   tap          : tap being evaluated
//   best_start   : first tap of the longest error-free run so far
//   best_len     : length of that run (0 = no clean tap seen)
//   center       : middle tap of the best run
module eye_run_tracker
    import adc_train_pkg::*;
#(
    parameter int TAPW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            eval,
    input  logic            pass,
    input  logic            last,
    input  logic [TAPW-1:0] tap,
    output logic [TAPW-1:0] best_start,
    output logic [TAPW:0]   best_len,
    output logic [TAPW-1:0] center
);

    localparam logic [TAPW:0] LEN_ONE = (TAPW+1)'(1);

    logic [TAPW-1:0] cur_start;
    logic [TAPW:0]   cur_len;
    logic [TAPW-1:0] run_start;
    logic [TAPW:0]   run_len;

    // The run as it stands once the current tap is folded in.
    always_comb begin
        run_start = cur_start;
        run_len   = cur_len;
        if (pass) begin
            if (cur_len == '0) begin
                run_start = tap;
            end
            run_len = cur_len + LEN_ONE;
        end
    end

    // A run closes on an errored tap or at the end of the sweep. Strict
    // greater-than keeps the earlier run when two runs are equally long.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (eval) begin
            if (!pass || last) begin
                if (run_len > best_len) begin
                    best_start <= run_start;
                    best_len   <= run_len;
                end
                cur_len <= '0;
            end else begin
                cur_start <= run_start;
                cur_len   <= run_len;
            end
        end
    end

    // best_start + floor(best_len/2) never exceeds the last tap, so the
    // sum fits in TAPW bits without wrapping.
    assign center = best_start + best_len[TAPW:1];

endmodule

// File: rtl/adc_delay_trainer.sv
// Per-lane ADC input-delay training controller. Sweeps every delay tap, runs
// the lane pattern checker for a fixed dwell at each one, then loads the
// centre of the longest error-free run of taps.
// Ports:
//   clk, reset    : ADC-domain clock, synchronous active-high reset
//   start         : one-cycle pulse, begin training (honoured only when idle)
//   chk_type      : pattern type for the checker (constant PATTERN)
//   chk_reset     : clears the checker error counter
//   chk_count     : checker count enable
//   chk_cnt       : checker saturating error counter
//   tap, tap_load : delay tap value and its one-cycle load strobe
//   busy, done    : training in progress / finished (done held until next start)
//   fail          : no error-free tap found, valid while done
//   eye_start     : first tap of the best run
//   eye_width     : length of the best run
module adc_delay_trainer
    import adc_train_pkg::*;
#(
    parameter int         TAPW    = 5,
    parameter int         SETTLE  = 16,
    parameter int         DWELL   = 1024,
    parameter int         DRAIN   = 3,
    parameter logic [3:0] PATTERN = PAT_PN9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [3:0]      chk_type,
    output logic            chk_reset,
    output logic            chk_count,
    input  logic [15:0]     chk_cnt,
    output logic [TAPW-1:0] tap,
    output logic            tap_load,
    output logic            busy,
    output logic            done,
    output logic            fail,
    output logic [TAPW-1:0] eye_start,
    output logic [TAPW:0]   eye_width
);

    localparam int TMAX = (DWELL > SETTLE) ? ((DWELL > DRAIN) ? DWELL : DRAIN)
                                           : ((SETTLE > DRAIN) ? SETTLE : DRAIN);
    localparam int TIMW = $clog2(TMAX + 1);

    localparam logic [TIMW-1:0] SETTLE_LAST = TIMW'(SETTLE - 1);
    localparam logic [TIMW-1:0] DWELL_LAST  = TIMW'(DWELL - 1);
    localparam logic [TIMW-1:0] DRAIN_LAST  = TIMW'(DRAIN - 1);
    localparam logic [TIMW-1:0] TIM_ONE     = TIMW'(1);
    localparam logic [TAPW-1:0] TAP_ONE     = TAPW'(1);

    train_state_t    state;
    logic [TIMW-1:0] timer;

    logic            trk_clear;
    logic            trk_eval;
    logic            tap_pass;
    logic            last_tap;
    logic [TAPW-1:0] best_start;
    logic [TAPW:0]   best_len;
    logic [TAPW-1:0] center_tap;

    assign chk_type  = PATTERN;
    assign trk_clear = (state == ST_IDLE) && start;
    assign trk_eval  = (state == ST_EVAL);
    assign tap_pass  = (chk_cnt == 16'h0000);
    assign last_tap  = &tap;

    eye_run_tracker #(
        .TAPW(TAPW)
    ) u_tracker (
        .clk       (clk),
        .reset     (reset),
        .clear     (trk_clear),
        .eval      (trk_eval),
        .pass      (tap_pass),
        .last      (last_tap),
        .tap       (tap),
        .best_start(best_start),
        .best_len  (best_len),
        .center    (center_tap)
    );

    // Training sequencer. Outputs are registered and set on the edge that
    // enters each state, so e.g. chk_count is high exactly while in DWELL.
    // The checker counter is held (chk_reset low) through DRAIN and EVAL so
    // the sampled count covers the whole dwell.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            timer     <= '0;
            tap       <= '0;
            tap_load  <= 1'b0;
            chk_count <= 1'b0;
            chk_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            eye_start <= '0;
            eye_width <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    chk_reset <= 1'b1;
                    chk_count <= 1'b0;
                    tap_load  <= 1'b0;
                    if (start) begin
                        tap      <= '0;
                        tap_load <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        fail     <= 1'b0;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tap_load  <= 1'b0;
                    chk_reset <= 1'b1;
                    timer     <= SETTLE_LAST;
                    state     <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (timer == '0) begin
                        chk_reset <= 1'b0;
                        chk_count <= 1'b1;
                        timer     <= DWELL_LAST;
                        state     <= ST_DWELL;
                    end else begin
                        timer <= timer - TIM_ONE;
                    end
                end
                ST_DWELL: begin
                    if (timer == '0) begin
                        chk_count <= 1'b0;
                        timer     <= DRAIN_LAST;
                        state     <= ST_DRAIN;
                    end else begin
                        timer <= timer - TIM_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (timer == '0) begin
                        state <= ST_EVAL;
                    end else begin
                        timer <= timer - TIM_ONE;
                    end
                end
                ST_EVAL: begin
                    if (last_tap) begin
                        state <= ST_CENTER;
                    end else begin
                        tap       <= tap + TAP_ONE;
                        tap_load  <= 1'b1;
                        chk_reset <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end
                ST_CENTER: begin
                    tap       <= (best_len == '0) ? '0 : center_tap;
                    fail      <= (best_len == '0);
                    eye_start <= best_start;
                    eye_width <= best_len;
                    tap_load  <= 1'b1;
                    state     <= ST_FIN;
                end
                ST_FIN: begin
                    tap_load  <= 1'b0;
                    chk_reset <= 1'b1;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_delay_trainer.sv
// Self-checking bench for adc_delay_trainer. Instance 0 uses the default
// timing for cycle-accurate checks; instance 1 uses short timers so many
// randomized eye patterns fit in the run.
module tb_adc_delay_trainer;
    import adc_train_pkg::*;

    localparam int P0 = 1 + 16 + 1024 + 3 + 1;
    localparam int P1 = 1 + 4 + 16 + 3 + 1;

    logic        clk;
    logic        reset;
    logic        start     [2];
    logic [3:0]  chk_type  [2];
    logic        chk_reset [2];
    logic        chk_count [2];
    logic [15:0] chk_cnt   [2];
    logic [4:0]  tap       [2];
    logic        tap_load  [2];
    logic        busy      [2];
    logic        done      [2];
    logic        fail      [2];
    logic [4:0]  eye_start [2];
    logic [5:0]  eye_width [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] bad_mask  [2];
    bit          last_only [2];
    bit          sat_mode  [2];
    bit          mon_en;
    int          tl_base   [2];

    int          tl_total  [2];
    logic [15:0] err_cnt   [2];
    logic        p1 [2];
    logic        p2 [2];
    logic        p3 [2];
    int          dwell_idx [2];

    int  last_load;
    int  cc_len;
    bit  prev_cc;

    adc_delay_trainer u_def (
        .clk      (clk),
        .reset    (reset),
        .start    (start[0]),
        .chk_type (chk_type[0]),
        .chk_reset(chk_reset[0]),
        .chk_count(chk_count[0]),
        .chk_cnt  (chk_cnt[0]),
        .tap      (tap[0]),
        .tap_load (tap_load[0]),
        .busy     (busy[0]),
        .done     (done[0]),
        .fail     (fail[0]),
        .eye_start(eye_start[0]),
        .eye_width(eye_width[0])
    );

    adc_delay_trainer #(
        .SETTLE(4),
        .DWELL (16),
        .DRAIN (3)
    ) u_fast (
        .clk      (clk),
        .reset    (reset),
        .start    (start[1]),
        .chk_type (chk_type[1]),
        .chk_reset(chk_reset[1]),
        .chk_count(chk_count[1]),
        .chk_cnt  (chk_cnt[1]),
        .tap      (tap[1]),
        .tap_load (tap_load[1]),
        .busy     (busy[1]),
        .done     (done[1]),
        .fail     (fail[1]),
        .eye_start(eye_start[1]),
        .eye_width(eye_width[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rangeMask(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Brute force: try every start tap, extend while clean, keep the first longest.
    function automatic void refEye(input logic [31:0] bad, output int s, output int w);
        int l;
        s = 0;
        w = 0;
        for (int a = 0; a < 32; a++) begin
            l = 0;
            while ((a + l) < 32 && !bad[a + l]) l++;
            if (l > w) begin
                w = l;
                s = a;
            end
        end
    endfunction

    function automatic logic errNow(input int k);
        int dl;
        dl = (k == 0) ? 1024 : 16;
        return chk_count[k] && bad_mask[k][tap[k]] && (!last_only[k] || dwell_idx[k] == dl - 1);
    endfunction

    // Pattern checker model: errors pass through a 3-stage pipe before the counter.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            p1[k] <= errNow(k);
            p2[k] <= p1[k];
            p3[k] <= p2[k];
            dwell_idx[k] <= chk_count[k] ? dwell_idx[k] + 1 : 0;
            if (chk_reset[k]) err_cnt[k] <= 16'h0;
            else if (p3[k] && err_cnt[k] != 16'hFFFF) err_cnt[k] <= err_cnt[k] + 16'h1;
        end
    end

    assign chk_cnt[0] = sat_mode[0] ? 16'hFFFF : err_cnt[0];
    assign chk_cnt[1] = sat_mode[1] ? 16'hFFFF : err_cnt[1];

    // Pulse counting and default-timing checks, sampled on the falling edge.
    always @(negedge clk) begin
        int idx;
        cyc++;
        for (int k = 0; k < 2; k++) if (!reset && tap_load[k]) tl_total[k]++;
        if (reset) begin
            cc_len  = 0;
            prev_cc = 1'b0;
        end else if (mon_en) begin
            idx = tl_total[0] - tl_base[0];
            if (tap_load[0]) begin
                if (idx > 1) checkOutput("load_period", cyc - last_load, (idx == 33) ? P0 + 1 : P0);
                last_load = cyc;
            end
            if (chk_count[0]) begin
                if (!prev_cc) checkOutput("settle_gap", cyc - last_load, 17);
                cc_len++;
            end else if (prev_cc) begin
                checkOutput("dwell_len", cc_len, 1024);
                cc_len = 0;
            end
            prev_cc = chk_count[0];
        end
    end

    task automatic applyStimulus(input int k, input logic [31:0] bad, input bit lastOnly,
                                 input bit sat, input bit poke);
        int s, w, n, per, exp_tap;
        per = (k == 0) ? P0 : P1;
        bad_mask[k]  = bad;
        last_only[k] = lastOnly;
        sat_mode[k]  = sat;
        refEye(sat ? 32'hFFFF_FFFF : bad, s, w);
        exp_tap = (w == 0) ? 0 : s + w / 2;
        tl_base[k] = tl_total[k];
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        n = 1;
        checkOutput("busy_run", busy[k], 1);
        checkOutput("done_clr", done[k], 0);
        while (!done[k] && n < 32 * per + 50) begin
            @(negedge clk);
            n++;
            if (poke && n == 60) start[k] = 1'b1;
            if (poke && n == 61) start[k] = 1'b0;
        end
        checkOutput("latency", n, 32 * per + 3);
        checkOutput("done", done[k], 1);
        checkOutput("busy_end", busy[k], 0);
        checkOutput("fail", fail[k], (w == 0) ? 1 : 0);
        checkOutput("eye_start", eye_start[k], s);
        checkOutput("eye_width", eye_width[k], w);
        checkOutput("final_tap", tap[k], exp_tap);
        checkOutput("load_pulses", tl_total[k] - tl_base[k], 33);
        repeat (3) @(negedge clk);
        checkOutput("done_hold", done[k], 1);
    endtask

    initial begin
        int n;
        logic [31:0] rmask;
        reset = 1'b1;
        mon_en = 1'b0;
        last_load = 0;
        cc_len = 0;
        prev_cc = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0;
            bad_mask[k] = '0;
            last_only[k] = 1'b0;
            sat_mode[k] = 1'b0;
            tl_base[k] = 0;
            tl_total[k] = 0;
            err_cnt[k] = '0;
            p1[k] = 1'b0;
            p2[k] = 1'b0;
            p3[k] = 1'b0;
            dwell_idx[k] = 0;
        end
        repeat (3) @(negedge clk);
        checkOutput("rst_tap", tap[0], 0);
        checkOutput("rst_tap_load", tap_load[0], 0);
        checkOutput("rst_chk_count", chk_count[0], 0);
        checkOutput("rst_chk_reset", chk_reset[0], 1);
        checkOutput("rst_busy", busy[0], 0);
        checkOutput("rst_done", done[0], 0);
        checkOutput("rst_fail", fail[0], 0);
        checkOutput("rst_eye_start", eye_start[0], 0);
        checkOutput("rst_eye_width", eye_width[0], 0);
        checkOutput("rst_chk_type", chk_type[0], PAT_PN9);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] default timing, errors injected on last dwell cycle only");
        mon_en = 1'b1;
        applyStimulus(0, ~rangeMask(10, 21), 1'b1, 1'b0, 1'b0);
        mon_en = 1'b0;

        $display("[TB] reset during dwell at tap 7");
        bad_mask[0] = '0;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        n = 0;
        while (!(tap[0] == 5'd7 && chk_count[0]) && n < 8 * P0 + 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_reach", (tap[0] == 5'd7 && chk_count[0]) ? 1 : 0, 1);
        repeat (200) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", busy[0], 0);
        checkOutput("abort_tap", tap[0], 0);
        checkOutput("abort_chk_count", chk_count[0], 0);
        checkOutput("abort_tap_load", tap_load[0], 0);
        checkOutput("abort_chk_reset", chk_reset[0], 1);
        reset = 1'b0;
        tl_base[0] = tl_total[0];
        repeat (20) @(negedge clk);
        checkOutput("abort_no_load", tl_total[0] - tl_base[0], 0);
        checkOutput("abort_idle_busy", busy[0], 0);
        checkOutput("abort_chk_type", chk_type[0], PAT_PN9);

        $display("[TB] short timing, directed patterns");
        applyStimulus(1, 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1, ~rangeMask(10, 21), 1'b0, 1'b0, 1'b0);
        applyStimulus(1, ~(rangeMask(2, 6) | rangeMask(20, 27)), 1'b0, 1'b0, 1'b0);
        applyStimulus(1, ~(rangeMask(0, 3) | rangeMask(10, 13)), 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 32'h0, 1'b0, 1'b1, 1'b0);

        $display("[TB] short timing, random patterns");
        for (int i = 0; i < 12; i++) begin
            rmask = $urandom() & $urandom();
            applyStimulus(1, rmask, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
